// File: rtl/ascon_perm_iter.sv
// Iterative Ascon permutation core that computes UNROLL (1 or 2) rounds per clock over a registered 320-bit state.
// Optional macro ASCON_PERM_ZEROIZE_EN clears the state register when a result is handed off.
module ascon_perm_iter #(
  parameter int UNROLL = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [4:0][63:0] in_state,
  input  logic [3:0]       in_rounds,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [4:0][63:0] out_state,
  output logic             busy
);

  if (UNROLL != 1 && UNROLL != 2) begin : g_bad_unroll
    $error("ascon_perm_iter: UNROLL must be 1 or 2");
  end

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } fsm_t;

  fsm_t             fsm, fsm_nxt;
  logic [4:0][63:0] state_p0, state_nxt;
  logic [4:0][63:0] rnd_p1, run_state;
  logic [3:0]       idx, idx_nxt, step, nr_eff;

  function automatic logic [63:0] rotr(input logic [63:0] x, input logic [5:0] n);
    return (x >> n) | (x << (7'd64 - {1'b0, n}));
  endfunction

  // One full round: constant addition, bitsliced S-box, per-lane diffusion.
  function automatic logic [4:0][63:0] ascon_round(input logic [4:0][63:0] s, input logic [3:0] i);
    logic [63:0] x0, x1, x2, x3, x4;
    logic [63:0] t0, t1, t2, t3, t4;
    x0 = s[0];
    x1 = s[1];
    x2 = s[2] ^ {56'h0, 4'hF - i, i};
    x3 = s[3];
    x4 = s[4];
    x0 = x0 ^ x4;
    x4 = x4 ^ x3;
    x2 = x2 ^ x1;
    t0 = ~x0 & x1;
    t1 = ~x1 & x2;
    t2 = ~x2 & x3;
    t3 = ~x3 & x4;
    t4 = ~x4 & x0;
    x0 = x0 ^ t1;
    x1 = x1 ^ t2;
    x2 = x2 ^ t3;
    x3 = x3 ^ t4;
    x4 = x4 ^ t0;
    x1 = x1 ^ x0;
    x0 = x0 ^ x4;
    x3 = x3 ^ x2;
    x2 = ~x2;
    x0 = x0 ^ rotr(x0, 6'd19) ^ rotr(x0, 6'd28);
    x1 = x1 ^ rotr(x1, 6'd61) ^ rotr(x1, 6'd39);
    x2 = x2 ^ rotr(x2, 6'd1)  ^ rotr(x2, 6'd6);
    x3 = x3 ^ rotr(x3, 6'd10) ^ rotr(x3, 6'd17);
    x4 = x4 ^ rotr(x4, 6'd7)  ^ rotr(x4, 6'd41);
    return {x4, x3, x2, x1, x0};
  endfunction

  // Stage p0 -> p1: first round of this clock.
  assign rnd_p1 = ascon_round(state_p0, idx);

  if (UNROLL == 2) begin : g_unroll2
    logic [4:0][63:0] rnd_p2;
    // Stage p1 -> p2: second round, bypassed when only one round remains.
    assign rnd_p2    = ascon_round(rnd_p1, idx + 4'd1);
    assign run_state = (idx == 4'd11) ? rnd_p1 : rnd_p2;
    assign step      = (idx == 4'd11) ? 4'd1 : 4'd2;
  end else begin : g_unroll1
    assign run_state = rnd_p1;
    assign step      = 4'd1;
  end

  assign nr_eff    = (in_rounds > 4'd12) ? 4'd12 : in_rounds;
  assign out_state = state_p0;

  always_ff @(posedge clk) begin
    if (rst) begin
      fsm      <= IDLE;
      state_p0 <= '0;
      idx      <= '0;
    end else begin
      fsm      <= fsm_nxt;
      state_p0 <= state_nxt;
      idx      <= idx_nxt;
    end
  end

  always_comb begin
    fsm_nxt   = fsm;
    state_nxt = state_p0;
    idx_nxt   = idx;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    unique case (fsm)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          state_nxt = in_state;
          idx_nxt   = 4'd12 - nr_eff;
          fsm_nxt   = (nr_eff == 4'd0) ? DONE : RUN;
        end
      end
      RUN: begin
        busy      = 1'b1;
        state_nxt = run_state;
        idx_nxt   = idx + step;
        if (idx + step == 4'd12) begin
          fsm_nxt = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          fsm_nxt = IDLE;
`ifdef ASCON_PERM_ZEROIZE_EN
          state_nxt = '0;
`else
          state_nxt = state_p0;
`endif
        end
      end
      default: fsm_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_ascon_perm_iter.sv
// Bench for ascon_perm_iter: UNROLL=1 and UNROLL=2 instances share stimulus and are checked every cycle
// against a table-driven Ascon reference model; honours ASCON_PERM_ZEROIZE_EN.
`timescale 1ns/1ps
module tb_ascon_perm_iter;

  typedef logic [4:0][63:0] st_t;

  localparam logic [4:0] SBOX [32] = '{
    5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
    5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
    5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
    5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17};
  localparam int RA [5] = '{19, 61, 1, 10, 7};
  localparam int RB [5] = '{28, 39, 6, 17, 41};

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       out_ready = 1'b1;
  st_t        in_state = '0;
  logic [3:0] in_rounds = '0;
  logic [1:0] ir, ov, bz;
  st_t        os0, os1;

  int  n_chk = 0;
  int  n_pass = 0;
  bit  chk_en = 1'b0;

  int  m_pend [2];
  int  m_cnt  [2];
  int  m_lat  [2];
  int  m_cons [2];
  int  hs     [2];
  st_t m_res  [2];
  st_t m_last [2];

  always #5 clk = ~clk;

  ascon_perm_iter #(.UNROLL(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[0]), .in_state(in_state),
    .in_rounds(in_rounds), .out_valid(ov[0]), .out_ready(out_ready), .out_state(os0), .busy(bz[0]));

  ascon_perm_iter #(.UNROLL(2)) dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[1]), .in_state(in_state),
    .in_rounds(in_rounds), .out_valid(ov[1]), .out_ready(out_ready), .out_state(os1), .busy(bz[1]));

  function automatic logic [63:0] rotr_m(input logic [63:0] x, input int n);
    logic [63:0] r;
    for (int k = 0; k < 64; k++) r[k] = x[(k + n) % 64];
    return r;
  endfunction

  // Reference permutation: S-box by table lookup on each bit column.
  function automatic st_t ref_perm(input st_t s_in, input int nr);
    st_t s, t;
    int n;
    logic [4:0] col, o;
    s = s_in;
    t = '0;
    n = (nr > 12) ? 12 : nr;
    for (int r = 12 - n; r < 12; r++) begin
      s[2] = s[2] ^ 64'(((15 - r) * 16) + r);
      for (int b = 0; b < 64; b++) begin
        col = {s[0][b], s[1][b], s[2][b], s[3][b], s[4][b]};
        o = SBOX[col];
        for (int j = 0; j < 5; j++) t[j][b] = o[4 - j];
      end
      for (int j = 0; j < 5; j++) s[j] = t[j] ^ rotr_m(t[j], RA[j]) ^ rotr_m(t[j], RB[j]);
    end
    return s;
  endfunction

  function automatic int lat_of(input int nr, input int unroll);
    int n;
    n = (nr > 12) ? 12 : nr;
    return (n + unroll - 1) / unroll + 1;
  endfunction

  function automatic st_t rand_st();
    st_t s;
    for (int j = 0; j < 5; j++) s[j] = {$urandom, $urandom};
    return s;
  endfunction

  task automatic chk(input string nm, input int u, input logic [319:0] got, input logic [319:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s dut%0d t=%0t got=%0h want=%0h", nm, u, $time, got, exp);
  endtask

  // Expected-behaviour model, advanced on each rising edge from the bench's own inputs.
  initial begin
    for (int u = 0; u < 2; u++) begin
      m_pend[u] = 0; m_cnt[u] = 0; m_lat[u] = 1; m_cons[u] = 0; hs[u] = 0;
      m_res[u] = '0; m_last[u] = '0;
    end
    forever begin
      @(posedge clk);
      for (int u = 0; u < 2; u++) begin
        if (rst) begin
          m_pend[u] = 0;
          m_last[u] = '0;
        end else if (m_pend[u] == 0) begin
          if (in_valid) begin
            m_pend[u] = 1;
            m_cnt[u]  = 1;
            m_lat[u]  = lat_of(int'(in_rounds), u + 1);
            m_res[u]  = ref_perm(in_state, int'(in_rounds));
          end
        end else if (m_cnt[u] >= m_lat[u] && out_ready) begin
          m_pend[u] = 0;
          m_cons[u]++;
`ifdef ASCON_PERM_ZEROIZE_EN
          m_last[u] = '0;
`else
          m_last[u] = m_res[u];
`endif
        end else begin
          m_cnt[u]++;
        end
      end
    end
  end

  // Compare process: every falling edge once reset has been applied.
  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        for (int u = 0; u < 2; u++) begin
          st_t o;
          logic exp_ov;
          o = (u == 0) ? os0 : os1;
          exp_ov = (m_pend[u] != 0) && (m_cnt[u] >= m_lat[u]);
          chk("out_valid", u, ov[u], exp_ov);
          chk("in_ready", u, ir[u], m_pend[u] == 0);
          chk("busy", u, bz[u], (m_pend[u] != 0) && (m_cnt[u] < m_lat[u]));
          if (exp_ov) chk("out_state", u, o, m_res[u]);
          else if (m_pend[u] == 0) chk("idle_state", u, o, m_last[u]);
          if (ov[u] && out_ready) hs[u]++;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    int g;
    g = 0;
    while (ir !== 2'b11 && g < 400) begin
      tick();
      g++;
    end
    if (g >= 400) chk("idle_timeout", 0, ir, 2'b11);
  endtask

  // rmode 0: out_ready high; 1: random back-pressure; 2: held low for 20 cycles.
  task automatic op(input st_t s, input int nr, input int rmode, input bit junk);
    int g;
    wait_idle();
    in_state  = s;
    in_rounds = 4'(nr);
    in_valid  = 1'b1;
    out_ready = 1'b1;
    tick();
    in_valid  = 1'b0;
    in_state  = rand_st();
    in_rounds = 4'($urandom_range(0, 15));
    g = 0;
    while (ir !== 2'b11 && g < 400) begin
      case (rmode)
        0: out_ready = 1'b1;
        1: out_ready = 1'($urandom_range(0, 1));
        default: out_ready = (g >= 20);
      endcase
      in_valid = junk && ($urandom_range(0, 2) == 0);
      tick();
      g++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    if (g >= 400) chk("op_timeout", 0, ir, 2'b11);
  endtask

  initial begin
    st_t z, rs, p;
    z = '0;

    tick();
    tick();
    rst = 1'b0;
    chk_en = 1'b1;

    p = ref_perm(z, 1);
    chk("pin_x0", 0, p[0], 64'h000964B00000004B);
    chk("pin_x1", 0, p[1], 64'h0000000096000213);
    chk("pin_x2", 0, p[2], 64'h53FFFFFFFFFFFF90);
    chk("pin_x3", 0, p[3], 64'h12E580000000004B);
    chk("pin_x4", 0, p[4], 64'h0);
    rs = rand_st();
    chk("pin_nr0", 0, ref_perm(rs, 0), rs);

    op(z, 1, 0, 1'b0);
    op(rs, 12, 0, 1'b0);
    op(rs, 8, 0, 1'b0);
    op(rs, 6, 0, 1'b0);
    op(rs, 5, 0, 1'b0);
    op(rs, 7, 0, 1'b0);
    op(rs, 0, 0, 1'b0);
    op(rs, 15, 0, 1'b0);
    op(rs, 13, 0, 1'b0);
    op(rs, 12, 0, 1'b0);

    op(rand_st(), 12, 2, 1'b0);
    op(rand_st(), 0, 2, 1'b0);
    for (int k = 0; k < 3; k++) op(rand_st(), 12, 0, 1'b1);

    // Reset in the third RUN cycle of a p12, then in DONE with a result pending.
    wait_idle();
    in_state = rand_st(); in_rounds = 4'd12; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    op(rand_st(), 12, 0, 1'b0);

    wait_idle();
    in_state = rand_st(); in_rounds = 4'd0; in_valid = 1'b1; out_ready = 1'b0;
    tick();
    in_valid = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    out_ready = 1'b1;
    op(rand_st(), 6, 0, 1'b0);

    for (int k = 0; k < 300; k++) op(rand_st(), $urandom_range(0, 15), 0, 1'b0);
    for (int k = 0; k < 200; k++) op(rand_st(), $urandom_range(0, 15), 1, 1'b1);

    wait_idle();
    tick();
    chk("handshakes", 0, hs[0], m_cons[0]);
    chk("handshakes", 1, hs[1], m_cons[1]);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
